// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: byte-lane masked stores, aligned and extended loads,
// a registered writeback bundle, and an optional wait-state counter that stalls upstream.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           memAddr,
  input  logic [31:0]           memData,
  input  logic                  readWr,
  input  logic                  writeWr,
  input  logic [3:0]            rmask,
  input  logic [3:0]            wmask,
  input  logic                  ld_unsigned,
  input  logic [31:0]           regcData_i,
  input  logic [4:0]            regcAddr_i,
  input  logic                  regcWr_i,
  output logic [31:0]           regcData,
  output logic [4:0]            regcAddr,
  output logic                  regcWr,
  output logic                  stall,
  output logic                  addr_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                  req;
  logic                  go;
  logic                  bad;
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [3:0]            size_mask;
  logic [3:0]            byte_en;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;
  logic [31:0]           shifted;
  logic [31:0]           ld_data;
  logic                  unused_addr_bits;

  assign req              = readWr | writeWr;
  assign word_idx         = memAddr[ADDR_WIDTH+1:2];
  assign lane             = memAddr[1:0];
  assign size_mask        = writeWr ? wmask : rmask;
  assign byte_en          = wmask << lane;
  assign unused_addr_bits = ^memAddr[31:ADDR_WIDTH+2];

  always_comb begin
    bad = 1'b0;
    case (size_mask)
      4'b0001: bad = 1'b0;
      4'b0011: bad = lane[0];
      4'b1111: bad = |lane;
      default: bad = 1'b1;
    endcase
    if (readWr && writeWr) bad = 1'b1;
  end

  always_comb begin
    case (wmask)
      4'b0001: wr_data = {4{memData[7:0]}};
      4'b0011: wr_data = {2{memData[15:0]}};
      default: wr_data = memData;
    endcase
  end

  // go marks the cycle whose ending edge commits the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    go      = 1'b0;
    if (WAIT_CYCLES == 0) begin
      go = req;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = S_IDLE;
            go      = req;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (rst) begin
      stall = 1'b0;
      go    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign we = go & writeWr & ~bad;
  assign re = go & readWr & ~bad;

  // One byte-wide RAM per lane keeps the byte enables a plain per-array write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (we && byte_en[gi]) mem[word_idx] <= wr_data[8*gi +: 8];
      if (re) rd_q <= mem[word_idx];
    end
    assign rd_word[8*gi +: 8] = rd_q;
  end

  logic [31:0] regc_data_q, regc_data_d;
  logic [4:0]  regc_addr_q, regc_addr_d;
  logic        regc_wr_q, regc_wr_d;
  logic        addr_err_q, addr_err_d;
  logic        load_q, load_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  // Stalled cycles hand WB a bubble; the load result is formatted after the RAM register.
  always_comb begin
    regc_data_d = regcData_i;
    regc_addr_d = regcAddr_i;
    regc_wr_d   = regcWr_i;
    addr_err_d  = 1'b0;
    load_d      = 1'b0;
    lane_d      = lane;
    size_d      = rmask[1] ? (rmask[3] ? 2'd2 : 2'd1) : 2'd0;
    uns_d       = ld_unsigned;
    if (stall) begin
      regc_data_d = regc_data_q;
      regc_addr_d = regc_addr_q;
      regc_wr_d   = 1'b0;
    end else if (go && bad) begin
      regc_data_d = 32'd0;
      regc_wr_d   = 1'b0;
      addr_err_d  = 1'b1;
    end else if (go && readWr) begin
      load_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regc_data_q <= 32'd0;
      regc_addr_q <= 5'd0;
      regc_wr_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      load_q      <= 1'b0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
    end else begin
      regc_data_q <= regc_data_d;
      regc_addr_q <= regc_addr_d;
      regc_wr_q   <= regc_wr_d;
      addr_err_q  <= addr_err_d;
      load_q      <= load_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  always_comb begin
    shifted = rd_word >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    ld_data = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    ld_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  assign regcData = load_q ? ld_data : regc_data_q;
  assign regcAddr = regc_addr_q;
  assign regcWr   = regc_wr_q;
  assign addr_err = addr_err_q;

endmodule
